// File: rtl/zle_xc4_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zle_xc4_fsm : controller FSM sequencing the zle_xc4_dp zero-RLE datapath  |
// | Optional end-of-stream flush enabled by defining ZLE_FLUSH_EN.            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module zle_xc4_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_valid,
    output logic       i_rd,
    input  logic       o_full,
    output logic       o_wr,
    output logic [3:0] state,
    input  logic       f_start_i_eq_0,
    input  logic       f_zeros_i_eq_0,
    input  logic       f_zeros_t_cnt_eq_15
`ifdef ZLE_FLUSH_EN
    ,
    input  logic       i_eos,
    output logic       eos_done
`endif
);

    localparam logic [3:0] S_START     = 4'd0;
    localparam logic [3:0] S_START_T   = 4'd1;
    localparam logic [3:0] S_START_E   = 4'd2;
    localparam logic [3:0] S_ZEROS     = 4'd3;
    localparam logic [3:0] S_ZEROS_T   = 4'd4;
    localparam logic [3:0] S_ZEROS_T_T = 4'd5;
    localparam logic [3:0] S_ZEROS_T_E = 4'd6;
    localparam logic [3:0] S_ZEROS_E   = 4'd7;
    localparam logic [3:0] S_PENDING   = 4'd8;

    logic [3:0] state_q;
    logic [3:0] state_d;

`ifdef ZLE_FLUSH_EN
    // Marks an S_ZEROS_E visit caused by end-of-stream rather than a literal.
    logic flush_q;
    logic flush_d;
    logic eos_w;
`endif

    always_comb begin
        state_d = state_q;
        i_rd    = 1'b0;
        o_wr    = 1'b0;
`ifdef ZLE_FLUSH_EN
        flush_d = 1'b0;
        eos_w   = 1'b0;
`endif
        case (state_q)
            S_START: begin
                if (i_valid) begin
                    state_d = f_start_i_eq_0 ? S_START_T : S_START_E;
                end
`ifdef ZLE_FLUSH_EN
                else if (i_eos) begin
                    eos_w = 1'b1;
                end
`endif
            end
            S_START_T: begin
                i_rd    = 1'b1;
                state_d = S_ZEROS;
            end
            S_START_E: begin
                if (!o_full) begin
                    i_rd    = 1'b1;
                    o_wr    = 1'b1;
                    state_d = S_START;
                end
            end
            S_ZEROS: begin
                // Run-token states clear cnt, so they are entered only when a write is possible.
                if (i_valid) begin
                    if (f_zeros_i_eq_0) begin
                        state_d = S_ZEROS_T;
                    end else if (!o_full) begin
                        state_d = S_ZEROS_E;
                    end
                end
`ifdef ZLE_FLUSH_EN
                else if (i_eos && !o_full) begin
                    state_d = S_ZEROS_E;
                    flush_d = 1'b1;
                end
`endif
            end
            S_ZEROS_T: begin
                if (!f_zeros_t_cnt_eq_15) begin
                    state_d = S_ZEROS_T_E;
                end else if (!o_full) begin
                    state_d = S_ZEROS_T_T;
                end
            end
            S_ZEROS_T_T: begin
                o_wr    = 1'b1;
                state_d = S_ZEROS;
            end
            S_ZEROS_T_E: begin
                i_rd    = 1'b1;
                state_d = S_ZEROS;
            end
            S_ZEROS_E: begin
                o_wr    = 1'b1;
`ifdef ZLE_FLUSH_EN
                eos_w   = flush_q;
                state_d = flush_q ? S_START : S_PENDING;
`else
                state_d = S_PENDING;
`endif
            end
            S_PENDING: begin
                if (!o_full) begin
                    i_rd    = 1'b1;
                    o_wr    = 1'b1;
                    state_d = S_START;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ZLE_FLUSH_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_d;
        end
    end

    // S_START pulses straight from i_eos, so hold it off while reset is active.
    assign eos_done = reset & eos_w;
`endif

    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_zle_xc4_fsm.sv
`default_nettype none
// Bench for zle_xc4_fsm: emulates the datapath and stream endpoints, scoreboards
// the encoded output against a token-level zero run-length reference model.
module tb_zle_xc4_fsm;

    logic       clock;
    logic       reset;
    logic       i_valid;
    logic       i_rd;
    logic       o_full;
    logic       o_wr;
    logic [3:0] state;
    logic       f_start_i_eq_0;
    logic       f_zeros_i_eq_0;
    logic       f_zeros_t_cnt_eq_15;
`ifdef ZLE_FLUSH_EN
    logic       i_eos;
    logic       eos_done;
    int         eos_cnt;
`endif

    zle_xc4_fsm dut (
        .clock               (clock),
        .reset               (reset),
        .i_valid             (i_valid),
        .i_rd                (i_rd),
        .o_full              (o_full),
        .o_wr                (o_wr),
        .state               (state),
        .f_start_i_eq_0      (f_start_i_eq_0),
        .f_zeros_i_eq_0      (f_zeros_i_eq_0),
        .f_zeros_t_cnt_eq_15 (f_zeros_t_cnt_eq_15)
`ifdef ZLE_FLUSH_EN
        ,
        .i_eos               (i_eos),
        .eos_done            (eos_done)
`endif
    );

    always #5 clock = ~clock;

    int         total;
    int         bad;
    logic [7:0] in_q[$];
    logic [8:0] exp_q[$];
    logic [3:0] trace[$];
    int         ex[$];
    logic [7:0] i_d;
    logic [8:0] dp_out;
    int         cnt;
    int         z;
    bit         rnd;
    bit         force_full;
    bit         pop_pending;
    logic       wr_prev;
    int         rd_cnt, wr_cnt, both_cnt, tt_cnt;
    int         issued, consumed;
    int         zp[3];
    logic [7:0] t;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference encoder: literal -> {0,value}; zero runs -> {1,length}, length capped at 15.
    task automatic issue(input logic [7:0] tok);
        in_q.push_back(tok);
        issued++;
        if (tok == 8'd0) begin
            if (z == 15) begin
                exp_q.push_back({1'b1, 8'd15});
                z = 1;
            end else begin
                z++;
            end
        end else begin
            if (z > 0) exp_q.push_back({1'b1, 8'(z)});
            z = 0;
            exp_q.push_back({1'b0, tok});
        end
    endtask

    task automatic start_window();
        @(posedge clock);
        trace.delete();
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; tt_cnt = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || state != 4'd0 || i_valid) && n < 3000) begin
            @(negedge clock);
            #4;
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d pending tokens expected 0", name, in_q.size() + exp_q.size());
        end
    endtask

    task automatic check_trace(input string name, input int e[$]);
        for (int i = 0; i < e.size(); i++) begin
            check(name, (i < trace.size()) ? int'(trace[i]) : -1, e[i]);
        end
    endtask

    // Upstream, downstream and datapath emulation.
    always @(negedge clock) begin
        if (pop_pending) begin
            i_valid     = 1'b0;
            pop_pending = 1'b0;
        end
        if (!i_valid && in_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            i_valid = 1'b1;
            i_d     = in_q[0];
        end
        if (force_full) o_full = 1'b1;
        else if (!rnd) o_full = 1'b0;
        else if (o_full) o_full = ($urandom_range(0, 1) == 1);
        else if (wr_prev) o_full = ($urandom_range(0, 2) == 0);
        f_start_i_eq_0      = (i_d == 8'd0);
        f_zeros_i_eq_0      = (i_d == 8'd0);
        f_zeros_t_cnt_eq_15 = (cnt == 15);
        #2;
        trace.push_back(state);
        if (i_rd) rd_cnt++;
        if (o_wr) wr_cnt++;
        if (i_rd && o_wr) both_cnt++;
        if (state == 4'd5) tt_cnt++;
`ifdef ZLE_FLUSH_EN
        if (eos_done && state == 4'd7) eos_cnt++;
`endif
        if (i_rd && !i_valid) begin
            total++; bad++;
            $display("FAIL read_without_valid: got i_rd=1 expected 0 in state %0d", state);
        end
        dp_out  = (state == 4'd5 || state == 4'd7) ? {1'b1, 8'(cnt)} : {1'b0, i_d};
        wr_prev = o_wr;
        if (i_rd) begin
            if (in_q.size() > 0) void'(in_q.pop_front());
            consumed++;
            pop_pending = 1'b1;
        end
        case (state)
            4'd1:       cnt = 1;
            4'd6:       cnt = cnt + 1;
            4'd5, 4'd7: cnt = 0;
            default:    ;
        endcase
    end

    // Scoreboard monitor.
    always @(negedge clock) begin
        logic [8:0] e;
        #3;
        if (o_wr) begin
            check("wr_while_full", int'(o_full), 0);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got token %0h expected none", dp_out);
            end else begin
                e = exp_q.pop_front();
                check("out_token", int'(dp_out), int'(e));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clock = 1'b0; reset = 1'b0; i_valid = 1'b0; o_full = 1'b0; i_d = 8'd0;
        f_start_i_eq_0 = 1'b0; f_zeros_i_eq_0 = 1'b0; f_zeros_t_cnt_eq_15 = 1'b0;
        total = 0; bad = 0; cnt = 0; z = 0; rnd = 1'b0; force_full = 1'b0;
        pop_pending = 1'b0; wr_prev = 1'b0; issued = 0; consumed = 0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; tt_cnt = 0;
        zp = '{50, 85, 95};
`ifdef ZLE_FLUSH_EN
        i_eos = 1'b1; eos_cnt = 0;
`endif
        repeat (3) @(posedge clock);
        @(negedge clock); #4;
        check("reset_state", int'(state), 0);
        check("reset_i_rd", int'(i_rd), 0);
        check("reset_o_wr", int'(o_wr), 0);
`ifdef ZLE_FLUSH_EN
        check("reset_eos_done", int'(eos_done), 0);
        i_eos = 1'b0;
`endif
        @(posedge clock); #1 reset = 1'b1;

        // Two literals.
        start_window(); issue(8'd3); issue(8'd5); drain("lit");
        ex = '{0, 2, 0, 2, 0}; check_trace("trace_lit", ex);
        check("lit_rd_wr_together", both_cnt, 2);
        check("lit_rd", rd_cnt, 2);

        // Short run terminated by a literal.
        start_window(); issue(8'd0); issue(8'd0); issue(8'd0); issue(8'd4); drain("run3");
        ex = '{0, 1, 3, 4, 6, 3, 4, 6, 3, 7, 8, 0}; check_trace("trace_run3", ex);
        check("run3_rd", rd_cnt, 4);
        check("run3_wr", wr_cnt, 2);

        // Saturating run.
        start_window();
        for (int k = 0; k < 17; k++) issue(8'd0);
        issue(8'd2); drain("run17");
        check("run17_saturate_writes", tt_cnt, 1);
        check("run17_rd", rd_cnt, 18);

        // Downstream full while a run-ending literal waits.
        start_window(); force_full = 1'b1; issue(8'd0); issue(8'd6);
        repeat (6) @(posedge clock);
        force_full = 1'b0; drain("full_hold");
        ex = '{0, 1, 3, 3, 3, 3, 3, 7, 8, 0}; check_trace("trace_full_hold", ex);
        check("full_hold_wr", wr_cnt, 2);

        // Reset mid-run.
        start_window(); issue(8'd0); issue(8'd0);
        begin
            int n = 0;
            do begin @(negedge clock); #4; n++; end while (state != 4'd6 && n < 50);
            check("reach_zeros_t_e", int'(state), 6);
        end
        reset = 1'b0; #1;
        check("midrun_reset_state", int'(state), 0);
        check("midrun_reset_i_rd", int'(i_rd), 0);
        check("midrun_reset_o_wr", int'(o_wr), 0);
        in_q.delete(); i_valid = 1'b0; pop_pending = 1'b0; cnt = 0; z = 0; issued = consumed;
        @(posedge clock); #1 reset = 1'b1;
        start_window(); issue(8'd7); drain("after_reset");
        ex = '{0, 2, 0}; check_trace("trace_after_reset", ex);

`ifdef ZLE_FLUSH_EN
        // End-of-stream flush of a trailing run.
        start_window(); eos_cnt = 0; issue(8'd0); issue(8'd0);
        begin
            int n = 0;
            do begin @(negedge clock); #4; n++; end
            while (!(state == 4'd3 && !i_valid && in_q.size() == 0) && n < 50);
        end
        i_eos = 1'b1;
        if (z > 0) exp_q.push_back({1'b1, 8'(z)});
        z = 0;
        repeat (3) @(posedge clock);
        #1 i_eos = 1'b0;
        drain("flush");
        check("flush_eos_pulse", eos_cnt, 1);
        check("flush_wr", wr_cnt, 1);
        check("flush_final_state", int'(state), 0);
`endif

        // Randomized streams with stalls and back-pressure.
        rnd = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 150; k++) begin
                t = ($urandom_range(0, 99) < zp[p]) ? 8'd0 : 8'($urandom_range(1, 255));
                if (k == 149 && t == 8'd0) t = 8'd1;
                issue(t);
                if ($urandom_range(0, 3) == 0) @(posedge clock);
            end
            drain("random");
        end
        rnd = 1'b0;
        repeat (2) @(posedge clock);
        check("reads_once", consumed, issued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
